dcsk_mod_core: RTL and testbench

Parametrised DCSK modulator that serialises an entire message word into reference/data chip pairs under its own chip sequencing, with no external chip index. It sits between the chaos generator and the channel/DAC interface in the TX path and generalises the fixed SF2–SF16 modulator. Key additions are a run-time spreading factor up to 2^MAX_SF_LOG2, a valid/ready message handshake, chip-enable pacing, and frame status outputs.

---
 rtl/dcsk_mod_core.sv | 185 ++++++++++++++++++
 tb/tb_dcsk_mod_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcsk_mod_core.sv
`default_nettype none
// ============================================================================
// Module   : dcsk_mod_core
// Purpose  : DCSK modulator. Serialises a whole message word into
//            reference/data chip pairs with its own chip sequencing, a
//            run-time spreading factor, valid/ready intake and chip-enable
//            pacing.
// Revision : 1.0 - initial release
// ============================================================================
module dcsk_mod_core #(
  parameter int MSG_WIDTH   = 32,
  parameter int MAX_SF_LOG2 = 5,
  localparam int SFW = $clog2(MAX_SF_LOG2 + 1),
  localparam int BW  = $clog2(MSG_WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic                 i_en,
  input  logic                 i_chaos_bit,
  input  logic [SFW-1:0]       i_sf_log2,
  input  logic [MSG_WIDTH-1:0] i_msg,
  input  logic                 i_msg_valid,
  output logic                 o_msg_ready,
  output logic                 o_serial,
  output logic                 o_chip_valid,
  output logic                 o_phase,
  output logic [BW-1:0]        o_bit_idx,
  output logic                 o_done
);

  localparam int C_DL = 1 << MAX_SF_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REF  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [MSG_WIDTH-1:0]   msg_q, msg_d;
  logic [SFW-1:0]         sf_q, sf_d;
  logic [MAX_SF_LOG2-1:0] chip_cnt_q, chip_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [C_DL-1:0]        delay_q;
  logic                   serial_q, serial_d;
  logic                   valid_q, valid_d;
  logic                   phase_q, phase_d;
  logic [BW-1:0]          idx_q, idx_d;
  logic                   done_q, done_d;

  logic [SFW-1:0]         sf_acc;
  logic [MAX_SF_LOG2-1:0] sf_m1;
  logic                   chip_last;
  logic                   tap;

  // Clamp the requested spreading factor into the supported SF2..SFmax range.
  always_comb begin
    sf_acc = i_sf_log2;
    if (i_sf_log2 == '0) begin
      sf_acc = SFW'(1);
    end else if (i_sf_log2 > SFW'(MAX_SF_LOG2)) begin
      sf_acc = SFW'(MAX_SF_LOG2);
    end
  end

  // SF-1 as a mask of sf_q ones: terminal chip count and delay-line tap index.
  always_comb begin
    sf_m1 = '0;
    for (int k = 0; k < MAX_SF_LOG2; k++) begin
      if (k < int'(sf_q)) sf_m1[k] = 1'b1;
    end
  end

  assign chip_last   = (chip_cnt_q == sf_m1);
  // delay_q[k] holds the chip from k+1 strobes ago, so index SF-1 is SF back.
  assign tap         = delay_q[sf_m1];
  assign o_msg_ready = (state_q == S_IDLE);

  // Chaos history: shifts on every strobe regardless of frame state.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      delay_q <= '0;
    end else if (i_en) begin
      delay_q <= {delay_q[C_DL-2:0], i_chaos_bit};
    end
  end

  // State, counters and registered chip outputs.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q    <= S_IDLE;
      msg_q      <= '0;
      sf_q       <= '0;
      chip_cnt_q <= '0;
      bit_cnt_q  <= '0;
      serial_q   <= 1'b0;
      valid_q    <= 1'b0;
      phase_q    <= 1'b0;
      idx_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      sf_q       <= sf_d;
      chip_cnt_q <= chip_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      serial_q   <= serial_d;
      valid_q    <= valid_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
    end
  end

  // Next-state: intake in IDLE, reference half in REF, modulated half in DATA.
  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    sf_d       = sf_q;
    chip_cnt_d = chip_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    serial_d   = serial_q;
    valid_d    = 1'b0;
    phase_d    = phase_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A strobe in the accept cycle only feeds the delay line.
        if (i_msg_valid) begin
          msg_d      = i_msg;
          sf_d       = sf_acc;
          chip_cnt_d = '0;
          bit_cnt_d  = BW'(MSG_WIDTH - 1);
          state_d    = S_REF;
        end
      end
      S_REF: begin
        if (i_en) begin
          serial_d = i_chaos_bit;
          valid_d  = 1'b1;
          phase_d  = 1'b0;
          idx_d    = bit_cnt_q;
          if (chip_last) begin
            chip_cnt_d = '0;
            state_d    = S_DATA;
          end else begin
            chip_cnt_d = chip_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (i_en) begin
          // Bit 1 repeats the reference chip, bit 0 inverts it.
          serial_d = tap ^ ~msg_q[MSG_WIDTH-1];
          valid_d  = 1'b1;
          phase_d  = 1'b1;
          idx_d    = bit_cnt_q;
          if (chip_last) begin
            chip_cnt_d = '0;
            if (bit_cnt_q == '0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q - 1'b1;
              msg_d     = {msg_q[MSG_WIDTH-2:0], 1'b0};
              state_d   = S_REF;
            end
          end else begin
            chip_cnt_d = chip_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_serial     = serial_q;
  assign o_chip_valid = valid_q;
  assign o_phase      = phase_q;
  assign o_bit_idx    = idx_q;
  assign o_done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dcsk_mod_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcsk_mod_core
// Purpose  : Self-checking bench for dcsk_mod_core (MSG_WIDTH=8,
//            MAX_SF_LOG2=5) against a chip-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcsk_mod_core;

  localparam int W    = 8;
  localparam int MAXL = 5;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       en, chaos, mval;
  logic [2:0] sfl;
  logic [7:0] msg;
  logic       ready, ser, cv, ph, done;
  logic [2:0] idx;

  int total = 0;
  int bad   = 0;

  // Every chaos chip presented on a strobe, in order.
  bit         hist[$];
  bit         m_ser = 1'b0;
  logic [7:0] msgs[4];
  logic [2:0] sfls[4];
  bit         pat8[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  dcsk_mod_core #(.MSG_WIDTH(W), .MAX_SF_LOG2(MAXL)) dut (
    .i_clk        (clk),
    .i_arst_n     (arst_n),
    .i_en         (en),
    .i_chaos_bit  (chaos),
    .i_sf_log2    (sfl),
    .i_msg        (msg),
    .i_msg_valid  (mval),
    .o_msg_ready  (ready),
    .o_serial     (ser),
    .o_chip_valid (cv),
    .o_phase      (ph),
    .o_bit_idx    (idx),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  function automatic int clampl(input logic [2:0] s);
    if (s == 3'd0) return 1;
    if (int'(s) > MAXL) return MAXL;
    return int'(s);
  endfunction

  // Runs nf frames from msgs/sfls; strobe every per cycles. Chip k of a frame
  // uses the k-th strobe after the accept strobe. abort_at >= 0 resets the DUT
  // once that many chips of a frame have been produced.
  task automatic run(input int nf, input int per, input bit pat, input int abort_at, input bit b2b);
    int fi, gen, nn, sf, cyc, s, b, w, ab;
    bit busy, busy_pre, pend, acc, e_ser, e_ph, e_done, e_bit, ch;
    logic [2:0] e_idx;
    logic [7:0] cur;
    fi = 0; gen = 0; nn = 0; sf = 2; cyc = 0; busy = 0; ab = abort_at; cur = '0;
    e_ser = 0; e_ph = 0; e_done = 0; e_idx = '0;
    forever begin
      ch    = pat ? pat8[hist.size() % 8] : 1'($urandom);
      en    = ((cyc % per) == 0);
      chaos = ch;
      cyc++;
      if (fi < nf) begin
        mval = 1'b1; msg = msgs[fi]; sfl = sfls[fi];
      end else begin
        mval = busy ? 1'($urandom) : 1'b0; msg = 8'($urandom); sfl = 3'($urandom);
      end
      busy_pre = busy;
      pend     = 1'b0;
      if (en) hist.push_back(ch);
      if (busy && en) begin
        s     = hist.size() - 1;
        b     = gen / (2 * sf);
        w     = gen % (2 * sf);
        e_bit = cur[7 - b];
        e_idx = 3'(7 - b);
        if (w < sf) begin
          e_ser = ch; e_ph = 1'b0;
        end else begin
          e_ser = hist[s - sf] ^ ~e_bit; e_ph = 1'b1;
        end
        e_done = (gen == nn - 1);
        pend   = 1'b1;
        gen++;
        if (gen == nn) busy = 1'b0;
      end
      acc = mval && !busy_pre;
      if (acc) begin
        if (b2b && fi > 0) begin
          total++;
          if (o_done_now() !== 1'b1) begin
            bad++; $display("FAIL b2b_accept_in_done_cycle: o_done=%0b want 1", done);
          end
        end
        cur = msgs[fi]; sf = 1 << clampl(sfls[fi]); nn = 2 * sf * W; gen = 0; busy = 1'b1; fi++;
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (cv !== pend) begin
        bad++; $display("FAIL chip_valid: got %0b want %0b (chip %0d)", cv, pend, gen);
      end
      total++;
      if (ready !== !busy) begin
        bad++; $display("FAIL msg_ready: got %0b want %0b", ready, !busy);
      end
      if (pend) begin
        total++;
        if (ser !== e_ser || ph !== e_ph || idx !== e_idx) begin
          bad++; $display("FAIL chip %0d: got ser=%0b ph=%0b idx=%0d want ser=%0b ph=%0b idx=%0d",
                          gen - 1, ser, ph, idx, e_ser, e_ph, e_idx);
        end
        total++;
        if (done !== e_done) begin
          bad++; $display("FAIL done_at_chip %0d: got %0b want %0b", gen - 1, done, e_done);
        end
        m_ser = e_ser;
      end else begin
        total++;
        if (ser !== m_ser) begin
          bad++; $display("FAIL serial_hold: got %0b want %0b", ser, m_ser);
        end
        total++;
        if (done !== 1'b0) begin
          bad++; $display("FAIL done_spurious: got %0b want 0", done);
        end
      end
      if (ab >= 0 && busy && gen == ab) begin
        arst_n = 1'b0;
        #1;
        total++;
        if ({ser, cv, ph, idx, done, ready} !== 8'b0000_0001) begin
          bad++; $display("FAIL midframe_reset_outputs: got %b want 00000001",
                          {ser, cv, ph, idx, done, ready});
        end
        m_ser = 1'b0;
        busy  = 1'b0;
        ab    = -1;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
      end
      if (fi >= nf && !busy) break;
      if (cyc > 20000) begin
        total++; bad++;
        $display("FAIL timeout: frame %0d chip %0d still pending, want completion", fi, gen);
        break;
      end
    end
    mval = 1'b0;
    en   = 1'b0;
  endtask

  function automatic logic o_done_now();
    return done;
  endfunction

  task automatic test_reset();
    arst_n = 1'b0; en = 0; chaos = 0; mval = 0; msg = '0; sfl = '0;
    #1;
    total++;
    if ({ser, cv, ph, idx, done, ready} !== 8'b0000_0001) begin
      bad++; $display("FAIL reset_outputs: got %b want 00000001", {ser, cv, ph, idx, done, ready});
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({ser, cv, ph, idx, done, ready} !== 8'b0000_0001) begin
      bad++; $display("FAIL reset_held: got %b want 00000001", {ser, cv, ph, idx, done, ready});
    end
    arst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || cv !== 1'b0) begin
      bad++; $display("FAIL idle_after_release: ready=%0b cv=%0b want 1/0", ready, cv);
    end
    m_ser = 1'b0;
  endtask

  task automatic test_sf2_pattern();
    msgs[0] = 8'hA5; sfls[0] = 3'd1;
    run(1, 1, 1'b1, -1, 1'b0);
  endtask

  task automatic test_sf32();
    msgs[0] = 8'h01; sfls[0] = 3'd5;
    run(1, 1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_sparse_en();
    msgs[0] = 8'hF0; sfls[0] = 3'd2;
    run(1, 3, 1'b0, -1, 1'b0);
  endtask

  task automatic test_sf_clamp();
    msgs[0] = 8'h3C; sfls[0] = 3'd0;
    msgs[1] = 8'hC3; sfls[1] = 3'd7;
    run(2, 1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    msgs[0] = 8'h96; sfls[0] = 3'd2;
    msgs[1] = 8'h5A; sfls[1] = 3'd1;
    run(2, 1, 1'b0, -1, 1'b1);
  endtask

  task automatic test_reset_midframe();
    msgs[0] = 8'hFF; sfls[0] = 3'd3;
    msgs[1] = 8'h6B; sfls[1] = 3'd3;
    run(2, 1, 1'b0, 10, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      msgs[i] = 8'($urandom);
      sfls[i] = 3'($urandom_range(0, 4));
    end
    run(4, $urandom_range(1, 3), 1'b0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sf2_pattern();
    test_sf32();
    test_sparse_en();
    test_sf_clamp();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
